// File: rtl/data_ram.sv
// data_ram: single-port word RAM behind a valid/ready request channel and a
// valid/ready response channel, with one outstanding request at a time.
// After reset the array is swept one word per cycle with the INIT_MODE pattern.
//
// Ports:
//   clk         single clock, rising edge
//   reset       synchronous, active-high
//   req_valid   request present
//   req_ready   request accepted this cycle (IDLE and not in reset)
//   req_write   1 = write, 0 = read
//   req_addr    word address; out-of-range addresses are flagged, never aliased
//   req_wdata   write data
//   req_wstrb   byte write enables
//   resp_valid  response present, held until resp_ready
//   resp_ready  consumer takes the response
//   resp_rdata  read data (0 for writes and errors)
//   resp_err    address was >= DEPTH
//
// state | meaning
// ------+-------------------------------------------------------------
// INIT  | sweep array with init pattern, one word per cycle
// IDLE  | ready for a request
// WAIT  | request accepted, counting down the extra latency cycles
// RESP  | response presented, waiting for resp_ready
module data_ram #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 32,
  parameter int LATENCY   = 1,
  parameter int INIT_MODE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int BYTES  = DATA_W / 8;
  // WAIT lasts LATENCY-1 cycles; the counter reaches its terminal count (0)
  // on the last of them.
  localparam logic [1:0] WAIT_LOAD = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    init_idx_q;
  logic [1:0]          wait_cnt_q;
  logic                ready_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                accept;
  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   init_word_d;
  logic [DATA_W-1:0]   wr_merge_d;

  // Gate with reset so the channel is closed during the reset cycle itself.
  assign req_ready  = ready_q & ~reset;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

  assign accept   = req_valid & req_ready;
  // Full-width range check: any set bit above the index field is an error.
  assign in_range = ((req_addr >> IDX_W) == '0);
  assign idx      = req_addr[IDX_W-1:0];

  assign init_word_d = (INIT_MODE != 0) ? DATA_W'(init_idx_q) : '0;

  always_comb begin
    wr_merge_d = mem_q[idx];
    for (int b = 0; b < BYTES; b++) begin
      if (req_wstrb[b]) begin
        wr_merge_d[8*b +: 8] = req_wdata[8*b +: 8];
      end
    end
  end

  // Array storage is not reset; it is rewritten by the INIT sweep instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == S_INIT) begin
        mem_q[init_idx_q] <= init_word_d;
      end else if (accept && req_write && in_range) begin
        mem_q[idx] <= wr_merge_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_INIT;
      init_idx_q   <= '0;
      wait_cnt_q   <= '0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        S_INIT: begin
          if (init_idx_q == IDX_W'(DEPTH - 1)) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
          end else begin
            init_idx_q <= init_idx_q + 1'b1;
          end
        end
        S_IDLE: begin
          if (accept) begin
            ready_q      <= 1'b0;
            resp_err_q   <= ~in_range;
            resp_rdata_q <= (in_range && !req_write) ? mem_q[idx] : '0;
            if (LATENCY == 1) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q    <= S_WAIT;
              wait_cnt_q <= WAIT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt_q == 2'd0) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
          end
        end
        default: state_q <= S_INIT;
      endcase
    end
  end

endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 16, number of words; SHALL be a power of two, 2..1024.
REQ-003 Parameter ADDR_W, default 32, request address width.
REQ-004 Parameter LATENCY, default 1, acceptance-to-response delay in cycles; legal range 1..4.
REQ-005 Parameter INIT_MODE, default 1: 0 = fill zeros; 1 = fill word index (word i = i, zero-extended).
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 req_valid  input  1  request present.
REQ-009 req_ready  output  1  block accepts a request this cycle.
REQ-010 req_write  input  1  1 = write, 0 = read.
REQ-011 req_addr  input  ADDR_W  word address.
REQ-012 req_wdata  input  DATA_W  write data.
REQ-013 req_wstrb  input  DATA_W/8  byte write enables; bit i covers bits [8i+7:8i].
REQ-014 resp_valid  output  1  response present.
REQ-015 resp_ready  input  1  consumer takes the response.
REQ-016 resp_rdata  output  DATA_W  read data; 0 for writes and errors.
REQ-017 resp_err  output  1  address out of range (req_addr >= DEPTH).

Function
REQ-018 FSM states SHALL be INIT, IDLE, WAIT and RESP.
REQ-019 INIT: one word per cycle, indices 0..DEPTH-1, written with the INIT_MODE pattern; req_ready=0; after word DEPTH-1 is written, next state is IDLE (DEPTH cycles total).
REQ-020 IDLE: req_ready=1; a request is accepted on an edge where req_valid=1 and req_ready=1.
REQ-021 On acceptance the full req_addr SHALL be compared against DEPTH; out of range gives err=1, no array access, and rdata=0.
REQ-022 Accepted in-range write: each byte with req_wstrb[i]=1 is updated at the acceptance edge; other bytes are unchanged; wstrb=0 still produces a response.
REQ-023 Accepted in-range read: array data at the acceptance edge is captured into the response register.
REQ-024 LATENCY=1: next state RESP; otherwise WAIT, holding for LATENCY-1 cycles (down-counter), then RESP.
REQ-025 resp_valid SHALL first be 1 exactly LATENCY cycles after the acceptance edge, i.e. in the cycle following edge N+LATENCY-1.
REQ-026 RESP: resp_valid=1; rdata and err are held stable until the edge where resp_ready=1; that edge returns the FSM to IDLE.
REQ-027 Exactly one outstanding request; req_ready=0 in WAIT, RESP and INIT; requests are not queued.
REQ-028 A back-to-back request needs at least one IDLE cycle; the next acceptance comes no earlier than the edge after the RESP handshake.
REQ-029 resp_ready while resp_valid=0 SHALL be ignored; req_valid while req_ready=0 SHALL be ignored and leave memory unchanged.
REQ-030 Array index SHALL be req_addr[log2(DEPTH)-1:0]; no wrap-around aliasing for out-of-range addresses (REQ-021).

Reset
REQ-031 reset=1 at an edge: state becomes INIT, init index 0, wait counter 0, resp_valid=0, resp_err=0, resp_rdata=0.
REQ-032 While reset is high, req_ready SHALL be 0.
REQ-033 Reset mid-operation (WAIT/RESP/INIT) drops any pending response and restarts the full INIT sweep; an in-flight write already committed at acceptance stays, then is overwritten by the sweep.
REQ-034 Reset has priority over every other event in the same cycle.

Verification
REQ-035 Defaults, release reset, wait 16 cycles -> req_ready rises after exactly 16 cycles; read addr 5 -> rdata=0x00000005, err=0, resp_valid one cycle after acceptance.
REQ-036 Write addr 3 data 0xAABBCCDD wstrb 0b0101, then read addr 3 -> 0x00BB00DD.
REQ-037 LATENCY=3: read addr 7 accepted at edge N -> resp_valid first high after edge N+2; with resp_ready held 0 for 5 cycles -> rdata=7 stable, req_ready=0 throughout.
REQ-038 Read addr 16 and write addr 0x100 -> err=1, rdata=0; contents of addr 0 unchanged (read back 0).
REQ-039 Assert reset in RESP state -> resp_valid=0 next cycle, 16-cycle INIT sweep, earlier write to addr 3 reads back 3.
REQ-040 INIT_MODE=0, DATA_W=64, DEPTH=64: after 64-cycle INIT, read addr 63 -> 0; write all-ones wstrb 0xFF then read -> 0xFFFFFFFFFFFFFFFF.
